// File: rtl/uart_tx_fifo.sv
// UART transmit back-end: byte FIFO feeding an 8N1 serialiser with a fixed baud divider.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit (8E1 framing).
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push_valid,
    input  logic [7:0]                  push_data,
    output logic                        push_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy,
    output logic                        tx
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   COUNT_FULL = (PW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [PW:0]   r_count;
    state_t        r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
`ifdef UART_TX_PARITY_EN
    logic          r_par;
`endif

    logic       w_full, w_push, w_pop, w_baud_done;
    logic [7:0] w_head;

    assign w_full      = (r_count == COUNT_FULL);
    assign w_push      = push_valid && !w_full;
    assign w_baud_done = (r_baud == BAUD_LAST);
    assign w_head      = r_mem[r_rptr];
    // The end of a stop bit pops directly into the next start bit so queued
    // frames leave back to back with no idle gap.
    assign w_pop       = (r_count != '0) &&
                         ((r_state == IDLE) || (r_state == STOP && w_baud_done));

    assign push_ready = !w_full;
    assign fifo_count = r_count;
    assign busy       = (r_state != IDLE) || (r_count != '0);
    assign tx         = r_tx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= push_data;
                r_wptr        <= r_wptr + PW'(1);
            end
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_tx    <= 1'b0;
                        r_baud  <= '0;
                        r_state <= START;
`ifdef UART_TX_PARITY_EN
                        r_par   <= ^w_head;
`endif
                    end
                end
                START: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_tx    <= r_shift[0];
                        r_bit   <= '0;
                        r_state <= DATA;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                DATA: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_par;
                            r_state <= PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= STOP;
`endif
                        end else begin
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                            r_bit   <= r_bit + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_tx    <= 1'b1;
                        r_state <= STOP;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
`endif
                STOP: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_tx    <= 1'b0;
                            r_state <= START;
`ifdef UART_TX_PARITY_EN
                            r_par   <= ^w_head;
`endif
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
